// File: rtl/round_sat_arbiter.sv
// Round-robin arbiter sharing one round/saturate datapath among NUM_REQ requesters.
// Two-stage valid/ready pipeline: S1 captures the granted word, S2 holds the rounded result.
module round_sat_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int T_0_DAT_WIDTH = 20,
  parameter int I_0_DAT_WIDTH = 16,
  parameter int ID_WIDTH      = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 t_valid,
  output logic [NUM_REQ-1:0]                 t_ready,
  input  logic [NUM_REQ*T_0_DAT_WIDTH-1:0]   t_dat,
  output logic                               i_valid,
  input  logic                               i_ready,
  output logic [I_0_DAT_WIDTH-1:0]           i_dat,
  output logic [ID_WIDTH-1:0]                i_id,
  output logic                               i_sat,
  input  logic                               sat_clr,
  output logic [CNT_WIDTH-1:0]               sat_cnt
);

  localparam int T = T_0_DAT_WIDTH;
  localparam int I = I_0_DAT_WIDTH;

  // Returns {sat, dat}. Top four bits are flags: neg, pre_sat, rnd, sgn.
  function automatic logic [I:0] round_sat(input logic [T-1:0] x);
    logic signed [I:0] r;
    r = $signed({x[I-1], x[I-1:0]}) + $signed({{I{1'b0}}, x[T-3]});
    if (x[T-1])
      return {1'b1, {I{1'b0}}};
    if (x[T-2] || (r[I] != r[I-1]))
      return {1'b1, x[T-4] ? {1'b1, {(I-1){1'b0}}} : {1'b0, {(I-1){1'b1}}}};
    return {1'b0, r[I-1:0]};
  endfunction

  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] win;
  logic                found;
  logic                grant;
  logic                adv1;
  logic                adv2;
  int                  idx;

  logic                vld_p1;
  logic [T-1:0]        dat_p1;
  logic [ID_WIDTH-1:0] id_p1;
  logic [I:0]          rs_p1;

  assign adv2  = !i_valid || i_ready;
  assign adv1  = !vld_p1 || adv2;
  assign grant = adv1 && found && !reset;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && t_valid[idx]) begin
        found = 1'b1;
        win   = ID_WIDTH'(idx);
      end
    end
  end

  assign t_ready = grant ? (NUM_REQ'(1) << win) : '0;

  // Stage p1: capture granted word and its tag
  always_ff @(posedge clk) begin
    if (grant) begin
      dat_p1 <= t_dat[win*T +: T];
      id_p1  <= win;
    end
  end

  assign rs_p1 = round_sat(dat_p1);

  // Stage p2: registered result, arbitration pointer and saturation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= ID_WIDTH'(NUM_REQ - 1);
      vld_p1  <= 1'b0;
      i_valid <= 1'b0;
      i_dat   <= '0;
      i_id    <= '0;
      i_sat   <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (adv1)
        vld_p1 <= grant;
      if (grant)
        ptr <= win;
      if (adv2) begin
        i_valid <= vld_p1;
        if (vld_p1) begin
          i_sat <= rs_p1[I];
          i_dat <= rs_p1[I-1:0];
          i_id  <= id_p1;
        end
      end
      if (sat_clr)
        sat_cnt <= '0;
      else if (adv2 && vld_p1 && rs_p1[I] && !(&sat_cnt))
        sat_cnt <= sat_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_round_sat_arbiter.sv
// Bench for round_sat_arbiter: directed scenarios plus randomized traffic against a
// cycle model built from arithmetic rounding rules and a round-robin search.
module tb_round_sat_arbiter;

  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  t_valid;
  logic [3:0]  t_ready;
  logic [79:0] t_dat;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_dat;
  logic [1:0]  i_id;
  logic        i_sat;
  logic        sat_clr;
  logic [15:0] sat_cnt;

  round_sat_arbiter #(
    .NUM_REQ(4), .T_0_DAT_WIDTH(20), .I_0_DAT_WIDTH(16), .ID_WIDTH(2), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .t_valid(t_valid), .t_ready(t_ready), .t_dat(t_dat),
    .i_valid(i_valid), .i_ready(i_ready), .i_dat(i_dat), .i_id(i_id), .i_sat(i_sat),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0]  tv = '0;
  logic [19:0] w [4];
  logic        ir = 1'b0;
  logic        clr = 1'b0;
  int          refill_mode = 0;

  assign t_valid = tv;
  assign t_dat   = {w[3], w[2], w[1], w[0]};
  assign i_ready = ir;
  assign sat_clr = clr;

  int          m_ptr, m_s1id, m_oid, m_cnt, e_win;
  bit          m_s1v, m_ov, m_s1s, m_os, adv1, adv2;
  logic [15:0] m_s1d, m_od;
  logic [3:0]  e_tready;

  function automatic logic [16:0] ref_rs(input logic [19:0] x);
    int d, r;
    logic [15:0] lo;
    if (x[19]) return 17'h10000;
    d = int'(x[15:0]);
    if (d > 32767) d = d - 65536;
    r = d + int'(x[17]);
    if (x[18] || r > 32767) return {1'b1, x[16] ? 16'h8000 : 16'h7FFF};
    lo = r[15:0];
    return {1'b0, lo};
  endfunction

  task automatic model_reset();
    m_ptr = NR - 1; m_s1v = 0; m_ov = 0; m_od = '0; m_oid = 0; m_os = 0; m_cnt = 0;
  endtask

  task automatic apply_reset();
    tv = '0; ir = 1'b0; clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Sample point: compute which requester should be accepted this cycle.
  task automatic eval();
    @(negedge clk);
    adv2 = !m_ov || ir;
    adv1 = !m_s1v || adv2;
    e_tready = '0;
    e_win = -1;
    if (adv1) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (e_win < 0 && tv[c]) e_win = c;
      end
    end
    if (e_win >= 0) e_tready[e_win] = 1'b1;
  endtask

  task automatic commit();
    if (clr) m_cnt = 0;
    else if (adv2 && m_s1v && m_s1s && m_cnt < 65535) m_cnt++;
    if (adv2) begin
      m_ov = m_s1v;
      if (m_s1v) begin m_od = m_s1d; m_oid = m_s1id; m_os = m_s1s; end
    end
    if (adv1) begin
      m_s1v = (e_win >= 0);
      if (e_win >= 0) begin
        {m_s1s, m_s1d} = ref_rs(w[e_win]);
        m_s1id = e_win;
        m_ptr  = e_win;
      end
    end
    @(posedge clk);
    #1;
    if (e_win >= 0) begin
      case (refill_mode)
        1:       w[e_win] = 20'($urandom);
        2:       w[e_win] = 20'h80000;
        default: tv[e_win] = 1'b0;
      endcase
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NR; k++) w[k] = 20'($urandom);
    tv = 4'hF; ir = 1'b1; clr = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (t_ready !== 4'b0) $display("FAIL reset_t_ready got=%b exp=0000", t_ready); else n_pass++;
    n_total++; if (i_valid !== 1'b0) $display("FAIL reset_i_valid got=%b exp=0", i_valid); else n_pass++;
    n_total++; if (i_dat !== 16'h0) $display("FAIL reset_i_dat got=%h exp=0000", i_dat); else n_pass++;
    n_total++; if (i_id !== 2'd0) $display("FAIL reset_i_id got=%0d exp=0", i_id); else n_pass++;
    n_total++; if (i_sat !== 1'b0) $display("FAIL reset_i_sat got=%b exp=0", i_sat); else n_pass++;
    n_total++; if (sat_cnt !== 16'h0) $display("FAIL reset_sat_cnt got=%h exp=0000", sat_cnt); else n_pass++;
    apply_reset();
  endtask

  task automatic test_first_result();
    refill_mode = 0;
    tv = 4'b0001; w[0] = 20'h01234; ir = 1'b1;
    eval();
    n_total++; if (t_ready !== 4'b0001) $display("FAIL first_t_ready got=%b exp=0001", t_ready); else n_pass++;
    commit();
    eval();
    n_total++; if (i_valid !== 1'b0) $display("FAIL first_latency1 i_valid got=%b exp=0", i_valid); else n_pass++;
    commit();
    eval();
    n_total++; if (i_valid !== 1'b1) $display("FAIL first_latency2 i_valid got=%b exp=1", i_valid); else n_pass++;
    n_total++; if ({i_dat, i_id, i_sat} !== {16'h1234, 2'd0, 1'b0})
      $display("FAIL first_result got=%h/%0d/%b exp=1234/0/0", i_dat, i_id, i_sat); else n_pass++;
    commit();
  endtask

  task automatic test_rounding();
    logic [19:0] vec  [4] = '{20'h27FFF, 20'h2FFFF, 20'h80000, 20'h50000};
    logic [15:0] edat [4] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
    logic        esat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] ecnt [4] = '{16'd1, 16'd1, 16'd2, 16'd3};
    refill_mode = 0;
    for (int v = 0; v < 4; v++) begin
      tv = 4'b0001; w[0] = vec[v];
      eval(); commit();
      eval(); commit();
      eval();
      n_total++;
      if ({i_valid, i_dat, i_sat, sat_cnt} !== {1'b1, edat[v], esat[v], ecnt[v]})
        $display("FAIL round_%0d got v=%b d=%h s=%b c=%0d exp v=1 d=%h s=%b c=%0d",
                 v, i_valid, i_dat, i_sat, sat_cnt, edat[v], esat[v], ecnt[v]);
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    refill_mode = 1;
    for (int k = 0; k < NR; k++) w[k] = 20'($urandom);
    tv = 4'hF; ir = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) begin tv = '0; refill_mode = 0; end
      eval();
      if (c < 8) begin
        n_total++;
        if (t_ready !== 4'(1 << (c % 4))) $display("FAIL rr_grant c=%0d got=%b exp=%b", c, t_ready, 4'(1 << (c % 4)));
        else n_pass++;
      end
      n_total++;
      if (i_valid !== (c >= 2)) $display("FAIL rr_valid c=%0d got=%b exp=%b", c, i_valid, (c >= 2));
      else n_pass++;
      if (c >= 2) begin
        n_total++;
        if ({i_id, i_dat, i_sat} !== {2'((c - 2) % 4), m_od, m_os})
          $display("FAIL rr_result c=%0d got=%0d/%h/%b exp=%0d/%h/%b", c, i_id, i_dat, i_sat, (c - 2) % 4, m_od, m_os);
        else n_pass++;
      end
      commit();
    end
  endtask

  task automatic test_back_to_back_stall();
    bit          ir_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit          prev_hold = 1'b0;
    logic [18:0] prev_exp = '0;
    int          n_in = 0, n_out = 0;
    refill_mode = 1;
    tv = 4'hF;
    for (int c = 0; c < 50; c++) begin
      if (c < 6) ir = ir_pat[c];
      else if (c < 44) ir = 1'($urandom_range(0, 1));
      else begin ir = 1'b1; tv = '0; refill_mode = 0; end
      eval();
      n_total++; if (t_ready !== e_tready) $display("FAIL stall_t_ready c=%0d got=%b exp=%b", c, t_ready, e_tready); else n_pass++;
      n_total++; if (i_valid !== m_ov) $display("FAIL stall_i_valid c=%0d got=%b exp=%b", c, i_valid, m_ov); else n_pass++;
      if (m_ov) begin
        n_total++;
        if ({i_dat, i_id, i_sat} !== {m_od, 2'(m_oid), m_os})
          $display("FAIL stall_result c=%0d got=%h/%0d/%b exp=%h/%0d/%b", c, i_dat, i_id, i_sat, m_od, m_oid, m_os);
        else n_pass++;
      end
      if (prev_hold) begin
        n_total++;
        if ({i_dat, i_id, i_sat} !== prev_exp) $display("FAIL stall_hold c=%0d got=%h exp=%h", c, {i_dat, i_id, i_sat}, prev_exp);
        else n_pass++;
      end
      if (m_s1v && m_ov && !ir) begin
        n_total++; if (t_ready !== 4'b0) $display("FAIL stall_full_ready c=%0d got=%b exp=0000", c, t_ready); else n_pass++;
      end
      if (e_win >= 0) n_in++;
      if (i_valid && ir) n_out++;
      prev_hold = m_ov && !ir;
      prev_exp  = {m_od, 2'(m_oid), m_os};
      commit();
    end
    n_total++; if (n_out !== n_in) $display("FAIL stall_count got=%0d exp=%0d", n_out, n_in); else n_pass++;
  endtask

  task automatic test_random();
    refill_mode = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (!tv[k]) begin
          if ($urandom_range(0, 1) == 1) begin
            tv[k] = 1'b1;
            w[k]  = {4'($urandom), 16'($urandom)};
            if ($urandom_range(0, 3) == 0) w[k][15:0] = 16'h7FFF;
          end
        end else if ($urandom_range(0, 9) == 0) tv[k] = 1'b0;
      end
      ir  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 29) == 0);
      eval();
      n_total++; if (t_ready !== e_tready) $display("FAIL rand_t_ready c=%0d got=%b exp=%b", c, t_ready, e_tready); else n_pass++;
      n_total++;
      if ({i_valid, sat_cnt} !== {m_ov, 16'(m_cnt)})
        $display("FAIL rand_valid_cnt c=%0d got=%b/%0d exp=%b/%0d", c, i_valid, sat_cnt, m_ov, m_cnt);
      else n_pass++;
      if (m_ov) begin
        n_total++;
        if ({i_dat, i_id, i_sat} !== {m_od, 2'(m_oid), m_os})
          $display("FAIL rand_result c=%0d got=%h/%0d/%b exp=%h/%0d/%b", c, i_dat, i_id, i_sat, m_od, m_oid, m_os);
        else n_pass++;
      end
      commit();
    end
    clr = 1'b0; tv = '0;
  endtask

  task automatic test_sat_counter();
    apply_reset();
    refill_mode = 2;
    for (int k = 0; k < NR; k++) w[k] = 20'h80000;
    tv = 4'hF; ir = 1'b1;
    for (int c = 0; c < 65540; c++) begin eval(); commit(); end
    for (int c = 0; c < 3; c++) begin
      eval();
      n_total++; if (sat_cnt !== 16'hFFFF) $display("FAIL sat_cnt_hold c=%0d got=%h exp=ffff", c, sat_cnt); else n_pass++;
      commit();
    end
    clr = 1'b1;
    eval(); commit();
    clr = 1'b0;
    eval();
    n_total++; if (sat_cnt !== 16'h0) $display("FAIL sat_clr_priority got=%h exp=0000", sat_cnt); else n_pass++;
    commit();
    eval();
    n_total++; if (sat_cnt !== 16'h1) $display("FAIL sat_cnt_restart got=%h exp=0001", sat_cnt); else n_pass++;
    commit();
  endtask

  task automatic test_reset_midflight();
    refill_mode = 1;
    for (int k = 0; k < NR; k++) w[k] = 20'($urandom);
    tv = 4'hF; ir = 1'b0;
    repeat (3) begin eval(); commit(); end
    n_total++; if (i_valid !== 1'b1) $display("FAIL midrst_pre_valid got=%b exp=1", i_valid); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (i_valid !== 1'b0) $display("FAIL midrst_async_valid got=%b exp=0", i_valid); else n_pass++;
    n_total++; if (t_ready !== 4'b0) $display("FAIL midrst_t_ready got=%b exp=0000", t_ready); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    ir = 1'b1;
    eval();
    n_total++; if (t_ready !== 4'b0001) $display("FAIL midrst_first_grant got=%b exp=0001", t_ready); else n_pass++;
    commit();
    eval();
    n_total++; if (i_valid !== 1'b0) $display("FAIL midrst_flushed got=%b exp=0", i_valid); else n_pass++;
    commit();
    refill_mode = 0; tv = '0;
  endtask

  initial begin
    for (int k = 0; k < NR; k++) w[k] = '0;
    test_reset();
    test_first_result();
    test_rounding();
    test_round_robin();
    test_back_to_back_stall();
    test_random();
    test_sat_counter();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/round_sat_arbiter.md
Name: round_sat_arbiter

Overview:
- Shares one round/saturate datapath among NUM_REQ requesters using a 2-stage valid/ready pipeline.
- Each requester presents 20-bit accumulator-format words and gets back 16-bit rounded/saturated results tagged with its requester index.
- Sits between the per-lane accumulators and the downstream sample packer.
- Arbitration is round-robin; the block also keeps a saturation-event counter for status readback.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- T_0_DAT_WIDTH, 20, input word width
- I_0_DAT_WIDTH, 16, output word width
- ID_WIDTH, 2, requester tag width; must be >= clog2(NUM_REQ)
- CNT_WIDTH, 16, saturation counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- t_valid  in  NUM_REQ  per-requester data valid
- t_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- t_dat  in  NUM_REQ*T_0_DAT_WIDTH  requester k occupies bits [k*T+T-1 : k*T]
- i_valid  out  1  result valid
- i_ready  in  1  downstream accept
- i_dat  out  I_0_DAT_WIDTH  rounded/saturated result
- i_id  out  ID_WIDTH  index of the requester that produced i_dat
- i_sat  out  1  result was forced by saturation or negative clamp
- sat_clr  in  1  synchronous clear of sat_cnt
- sat_cnt  out  CNT_WIDTH  count of results with i_sat=1

Behaviour:
- Reset values:
  - t_ready=0, i_valid=0, i_dat=0, i_id=0, i_sat=0, sat_cnt=0
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Handshake:
  - A transfer occurs on a cycle where valid&ready are both high.
  - t_ready is combinational from t_valid and pipeline state.
  - Upstream holds t_dat stable while t_valid=1 and not accepted.
  - Output holds i_dat/i_id/i_sat stable while i_valid=1 and i_ready=0.
- Pipeline:
  - S1 is the capture register (data+id). S2 is the output register (i_*).
  - advance2 = !i_valid | i_ready
  - advance1 = !s1_valid | advance2
  - Grant only when advance1=1.
  - Latency is 2 cycles from the input transfer edge to i_valid.
  - Full throughput: 1 result/cycle when i_ready stays high.
  - No bubble insertion, no data loss under arbitrary i_ready patterns.
- Arbitration:
  - Search t_valid starting at pointer+1 modulo NUM_REQ; the first set bit wins.
  - On a grant the pointer becomes the winner index; with no grant the pointer holds.
  - A single active requester receives a grant every cycle.
- Datapath (S1→S2), with x = s1 data and d = x[T-5:0] (16 bits):
  - neg = x[T-1], pre_sat = x[T-2], rnd = x[T-3], sgn = x[T-4].
  - r = sign-extend(d) to 17 bits + rnd.
  - If neg: i_dat=0, i_sat=1.
  - Else if pre_sat or r[16]!=r[15]: i_dat = sgn ? 16'h8000 : 16'h7FFF, i_sat=1.
  - Else: i_dat = r[15:0], i_sat=0.
- sat_cnt:
  - Increments when an S2 load with i_sat=1 occurs.
  - Saturates at all-ones; no wrap.
  - sat_clr has priority over an increment in the same cycle.
- Reset mid-operation: S1/S2 contents are discarded and the pointer returns to NUM_REQ-1.
- t_valid deasserted without a transfer is legal; no state change results.

Test Plan:
- Reset, then t_valid=4'b0001, t_dat[19:0]=20'h01234, i_ready=1 → t_ready=0001 same cycle; 2 cycles later i_valid=1, i_dat=16'h1234, i_id=0, i_sat=0.
- Rounding/overflow:
  - 20'h27FFF → 16'h7FFF, i_sat=1, sat_cnt=1.
  - 20'h2FFFF → 16'h0000, i_sat=0.
  - 20'h80000 → 16'h0000, i_sat=1.
  - 20'h50000 → 16'h8000, i_sat=1.
- All four t_valid held high, i_ready=1, 8 cycles → grant order 0,1,2,3,0,1,2,3; i_id sequence matches; 1 result/cycle.
- All requesters valid, i_ready toggles 1,0,0,1,0,1 → no result lost or duplicated; outputs stable during stalls; t_ready=0 while S1 and S2 are both full and stalled.
- Force sat_cnt to all-ones via 65535+ saturating inputs → holds at 16'hFFFF. Assert sat_clr together with a saturating S2 load → sat_cnt=0.
- Assert reset with S1 and S2 both full → i_valid=0 immediately (async); after release, t_valid=4'b1111 → first grant goes to requester 0.
